// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : Host-side SPI master (mode 0) for the command/address/data
//            register protocol. Divides clk down to sclk and shifts out a
//            command byte, an address byte and 1-16 data bytes MSB-first.
//            For read commands (cmd[0]=1) it collects the miso bytes.
// Params   : CLK_DIV - sclk half-period in clk cycles (>= 2)
//            CNT_W   - divider counter width (2^CNT_W > CLK_DIV)
// Ports    : clk, rst            - system clock, synchronous active-high reset
//            start, cmd, addr,   - transaction request (sampled when !busy)
//            len
//            tx_data / tx_ack    - write byte supply / one-cycle consume pulse
//            rx_data / rx_valid  - received byte / one-cycle update pulse
//            busy, done          - activity flag / end-of-transaction pulse
//            csn, sclk, mosi,    - SPI pins
//            miso
// Macro    : SPI_MASTER_CS_GAP_EN - adds a GAP state that keeps csn high and
//            busy asserted for 2*CLK_DIV cycles after each transaction.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic [7:0] addr,
  input  logic [3:0] len,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       csn,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] div_cnt;
  logic [7:0]       bit_cnt;     // index of the bit currently on the wire
  logic [7:0]       last_bit;    // index of the final bit, 16 + 8*(len+1) - 1
  logic [7:0]       cmd_r;
  logic [7:0]       addr_r;
  logic [6:0]       tx_sh;       // remaining bits of the current write byte
  logic [6:0]       rx_sh;
  logic             mosi_r;
  logic             gap_half;

  logic             div_end;
  logic             accept;
  logic             sclk_rise;
  logic             sclk_fall;
  logic             last_fall;
  logic             hold_end;
  logic             gap_end;
  logic [7:0]       nb;
  logic             byte_boundary;
  logic             ack_set;
  logic             rx_sample;
  logic             next_bit;

  assign div_end       = (div_cnt == DIV_LAST);
  assign nb            = bit_cnt + 8'd1;
  assign byte_boundary = (nb >= 8'd16) && (nb[2:0] == 3'd0);
  assign ack_set       = sclk_fall && !last_fall && !cmd_r[0] && byte_boundary;
  // First clk cycle of each sclk-high phase in the data phase of a read.
  assign rx_sample     = (state == SHIFT) && sclk && (div_cnt == '0) &&
                         (bit_cnt >= 8'd16) && cmd_r[0];

  // The MSB of a write byte goes out in the same cycle tx_ack requests it,
  // so mosi bypasses the register while tx_ack is high.
  assign mosi = tx_ack ? tx_data[7] : mosi_r;

  // Bit presented after the falling edge that ends bit bit_cnt.
  always_comb begin
    next_bit = 1'b0;
    if (nb < 8'd8) begin
      next_bit = cmd_r[~nb[2:0]];
    end else if (nb < 8'd16) begin
      next_bit = addr_r[~nb[2:0]];
    end else if (!cmd_r[0] && !byte_boundary) begin
      next_bit = tx_sh[~nb[2:0]];
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
    last_fall = 1'b0;
    hold_end  = 1'b0;
    gap_end   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (div_end) begin
          sclk_rise = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (div_end) begin
          if (!sclk) begin
            sclk_rise = 1'b1;
          end else begin
            sclk_fall = 1'b1;
            if (bit_cnt == last_bit) begin
              last_fall = 1'b1;
              state_nxt = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          hold_end  = 1'b1;
`ifdef SPI_MASTER_CS_GAP_EN
          state_nxt = GAP;
`else
          state_nxt = IDLE;
`endif
        end
      end
      GAP: begin
        // Two divider periods: first sets gap_half, second ends the gap.
        if (div_end && gap_half) begin
          gap_end   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= 8'd0;
      last_bit <= 8'd0;
      cmd_r    <= 8'd0;
      addr_r   <= 8'd0;
      tx_sh    <= 7'd0;
      rx_sh    <= 7'd0;
      mosi_r   <= 1'b0;
      gap_half <= 1'b0;
      csn      <= 1'b1;
      sclk     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_ack   <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      done     <= 1'b0;
      rx_valid <= 1'b0;
      tx_ack   <= ack_set;

      if (state == IDLE || div_end) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end

      if (accept) begin
        cmd_r    <= cmd;
        addr_r   <= addr;
        last_bit <= 8'd23 + {1'b0, len, 3'b000};
        bit_cnt  <= 8'd0;
        mosi_r   <= cmd[7];
        csn      <= 1'b0;
        busy     <= 1'b1;
        gap_half <= 1'b0;
      end

      if (sclk_rise) begin
        sclk <= 1'b1;
      end

      if (sclk_fall) begin
        sclk    <= 1'b0;
        bit_cnt <= nb;
        mosi_r  <= last_fall ? 1'b0 : next_bit;
      end

      // Write byte is consumed at the end of the tx_ack cycle.
      if (tx_ack) begin
        tx_sh  <= tx_data[6:0];
        mosi_r <= tx_data[7];
      end

      if (rx_sample) begin
        rx_sh <= {rx_sh[5:0], miso};
        if (bit_cnt[2:0] == 3'd7) begin
          rx_data  <= {rx_sh, miso};
          rx_valid <= 1'b1;
        end
      end

      if (hold_end) begin
        csn      <= 1'b1;
        done     <= 1'b1;
        gap_half <= 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
        busy     <= 1'b1;
`else
        busy     <= 1'b0;
`endif
      end

      if (state == GAP && div_end) begin
        gap_half <= 1'b1;
      end

      if (gap_end) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
